// File: rtl/programmable_delay_line_pkg.sv
// Shared helpers for programmable_delay_line: delay clamping and pointer/select width computation.
package programmable_delay_line_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned sel_width(input int unsigned max_delay);
    return $clog2(max_delay + 1);
  endfunction

  function automatic int unsigned clamp_delay(input int unsigned sel, input int unsigned max_delay);
    if (sel == 0) return 1;
    if (sel > max_delay) return max_delay;
    return sel;
  endfunction

endpackage

// File: rtl/programmable_delay_line_mem.sv
// delay_line_mem: DEPTH x (WIDTH+1) simple dual-port store, combinational read (old data during write).
module delay_line_mem
  import programmable_delay_line_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  localparam int unsigned AW = ptr_width(DEPTH)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WIDTH:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [WIDTH:0] rdata
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;

  // Payload is deliberately never reset; only the per-entry valid bit is cleared.
  always_ff @(posedge clk) begin
    if (we) data_q[waddr] <= wdata[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else if (we) valid_q[waddr] <= wdata[WIDTH];
  end

  assign rdata = {valid_q[raddr], data_q[raddr]};

endmodule

// File: rtl/programmable_delay_line.sv
// Programmable delay line over a circular buffer. Define PROGRAMMABLE_DELAY_LINE_OUTREG_EN
// to add a clkEn-gated output register (latency D+1 advances).
module programmable_delay_line
  import programmable_delay_line_pkg::*;
#(
  parameter int unsigned     WIDTH       = 32,
  parameter int unsigned     MAX_DELAY   = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clkEn,
  input  logic [sel_width(MAX_DELAY)-1:0] delaySel,
  input  logic                            delayLoad,
  input  logic                            validIn,
  input  logic [WIDTH-1:0]                din,
  output logic                            validOut,
  output logic [WIDTH-1:0]                dout,
  output logic                            filling
);

  localparam int unsigned DW = sel_width(MAX_DELAY);
  localparam int unsigned PW = ptr_width(MAX_DELAY);
  localparam int unsigned CW = DW + 1;
`ifdef PROGRAMMABLE_DELAY_LINE_OUTREG_EN
  localparam int unsigned EXTRA = 1;
`else
  localparam int unsigned EXTRA = 0;
`endif

  logic          advance;
  logic [DW-1:0] delay_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_idx;
  logic [PW:0]   rd_sum;
  logic [CW-1:0] fill_cnt;
  logic [CW-1:0] fill_target;
  logic [WIDTH:0] rd_word;

  assign advance     = clkEn && !delayLoad;
  assign fill_target = CW'(delay_q) + CW'(EXTRA);
  assign filling     = fill_cnt < fill_target;

  // Offset by MAX_DELAY before subtracting so the modulo never goes negative.
  always_comb begin
    rd_sum = {1'b0, wr_ptr} + (PW + 1)'(MAX_DELAY) - (PW + 1)'(delay_q);
    rd_idx = (rd_sum >= (PW + 1)'(MAX_DELAY)) ? PW'(rd_sum - (PW + 1)'(MAX_DELAY)) : PW'(rd_sum);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      delay_q  <= DW'(MAX_DELAY);
      wr_ptr   <= '0;
      fill_cnt <= '0;
    end else if (delayLoad) begin
      delay_q  <= DW'(clamp_delay(32'(delaySel), MAX_DELAY));
      fill_cnt <= '0;
    end else if (clkEn) begin
      wr_ptr <= (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
      if (fill_cnt < fill_target) fill_cnt <= fill_cnt + CW'(1);
    end
  end

  delay_line_mem #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY)
  ) u_mem (
    .clk   (clk),
    .clr   (rst || delayLoad),
    .we    (advance && !rst),
    .waddr (wr_ptr),
    .wdata ({validIn, din}),
    .raddr (rd_idx),
    .rdata (rd_word)
  );

`ifdef PROGRAMMABLE_DELAY_LINE_OUTREG_EN
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;

  always_ff @(posedge clk) begin
    if (rst || delayLoad) begin
      out_valid_q <= 1'b0;
    end else if (clkEn) begin
      out_valid_q <= rd_word[WIDTH];
      out_data_q  <= rd_word[WIDTH-1:0];
    end
  end

  assign validOut = out_valid_q;
  assign dout     = out_valid_q ? out_data_q : RESET_VALUE;
`else
  assign validOut = rd_word[WIDTH];
  assign dout     = rd_word[WIDTH] ? rd_word[WIDTH-1:0] : RESET_VALUE;
`endif

endmodule

// File: doc/programmable_delay_line.md
PROGRAMMABLE_DELAY_LINE -- requirements
Module: programmable_delay_line

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning the data word width in bits (>=1).
REQ-002 The block SHALL have parameter MAX_DELAY, default 32, meaning the largest programmable delay in advances (2..1024).
REQ-003 The block SHALL have parameter RESET_VALUE, default 0, meaning the value driven on dout whenever validOut is 0.
REQ-004 The block SHALL have port clk, input, 1 bit, the clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst, input, 1 bit, the reset: synchronous, active-high.
REQ-006 The block SHALL have port clkEn, input, 1 bit: advance the line by one slot this cycle.
REQ-007 The block SHALL have port delaySel, input, DW = clog2(MAX_DELAY+1) bits: the requested delay.
REQ-008 The block SHALL have port delayLoad, input, 1 bit: latch delaySel and flush the line.
REQ-009 The block SHALL have port validIn, input, 1 bit: din carries a valid word.
REQ-010 The block SHALL have port din, input, WIDTH bits: the input data word.
REQ-011 The block SHALL have port validOut, output, 1 bit: dout carries a valid word.
REQ-012 The block SHALL have port dout, output, WIDTH bits: the delayed data word.
REQ-013 The block SHALL have port filling, output, 1 bit: high while fewer than D advances have happened since the last flush.

Function
REQ-014 The active delay D SHALL be latched from delaySel on delayLoad; 0 clamps to 1 and values >MAX_DELAY clamp to MAX_DELAY.
REQ-015 An advance SHALL be a cycle with clkEn=1 and delayLoad=0; each advance captures {validIn,din} once.
REQ-016 A word captured at advance k SHALL appear on {validOut,dout} after advance k+D, held until the next advance; no state changes when clkEn=0.
REQ-017 Storage SHALL be a circular buffer of MAX_DELAY entries; the write pointer increments per advance and wraps MAX_DELAY-1 -> 0; read index = (wrPtr - D) mod MAX_DELAY.
REQ-018 delayLoad SHALL take priority over clkEn; the word offered in that cycle is discarded.
REQ-019 delayLoad SHALL clear every stored valid bit; validOut SHALL be 0 from the next cycle until D advances after the load.
REQ-020 fillCnt SHALL reset to 0 on flush, increment per advance, and saturate at D; filling = (fillCnt < D).
REQ-021 dout SHALL equal RESET_VALUE whenever validOut=0.
REQ-022 With D=MAX_DELAY, every entry SHALL be live; read-during-write SHALL return the old data.

Reset
REQ-023 rst SHALL set D=MAX_DELAY, pointers=0, fillCnt=0, all valid bits=0, validOut=0, dout=RESET_VALUE, filling=1.
REQ-024 rst SHALL override delayLoad and clkEn in the same cycle; reset mid-stream SHALL discard all in-flight words.
REQ-025 The data payload array SHALL NOT be reset; only valid bits and control state are reset.

Configuration
REQ-026 Macro PROGRAMMABLE_DELAY_LINE_OUTREG_EN SHALL add one clkEn-gated output register stage; latency becomes D+1 advances and filling covers D+1 advances.
REQ-027 Without PROGRAMMABLE_DELAY_LINE_OUTREG_EN, latency SHALL be exactly D advances as in REQ-016.

Structure
REQ-028 The shared package SHALL hold the delay clamp function and the pointer-width constant computation.
REQ-029 Storage SHALL be the sub-module delay_line_mem: a simple dual-port array of MAX_DELAY x (WIDTH+1) with old-data read-during-write; control logic stays in the top.

Verification
REQ-030 Reset, then delayLoad with delaySel=5, then clkEn=1 continuously with din=1,2,3,... -> validOut first rises on the 5th advance with dout=1; filling falls the same cycle.
REQ-031 D=4, clkEn toggling 1,0,1,0 -> output is identical per advance and dout holds during clkEn=0 cycles.
REQ-032 delaySel=0 -> D=1; delaySel=MAX_DELAY+7 -> D=MAX_DELAY; run 3*MAX_DELAY advances to check pointer wrap with no lost or duplicated words.
REQ-033 Mid-stream delayLoad 8->3 with clkEn=1 -> input that cycle is dropped, validOut=0 for 3 advances, then the post-load words appear in order.
REQ-034 validIn pattern 1,0,1,1 at D=2 -> validOut follows 1,0,1,1 two advances later, with dout=RESET_VALUE on the invalid slot.
REQ-035 rst asserted while full at D=6 with delayLoad=1 in the same cycle -> reset state per REQ-023 and D=MAX_DELAY; with OUTREG_EN the latency in REQ-030 becomes 6.
